// File: rtl/osnt_tx_queue_sf.sv
// Store-and-forward TX queue: buffers whole packets, drops packets that do not fit,
// and stamps a timestamp / {seq, signature} word on egress with a programmable gap.
module osnt_tx_queue_sf #(
    parameter int          C_AXIS_DATA_WIDTH    = 64,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int          C_S_AXI_DATA_WIDTH   = 32,
    parameter int          TS_WIDTH             = 64,
    parameter int          FIFO_DEPTH_BITS      = 9,
    parameter logic [31:0] SIGNATURE            = 32'hefbeadde
) (
    input  logic                              axis_aclk,
    input  logic                              axis_reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic                              m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    input  logic                              clear,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     tx_ts_pos,
    input  logic                              tx_sig_en,
    input  logic [15:0]                       tx_ipg,
    input  logic [TS_WIDTH-1:0]               timestamp_156,
    output logic [31:0]                       tx_pkt_count,
    output logic [31:0]                       tx_drop_count
);
    localparam int DW    = C_AXIS_DATA_WIDTH;
    localparam int KW    = C_AXIS_DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;

    typedef logic [FIFO_DEPTH_BITS-1:0] ptr_t;
    typedef logic [FIFO_DEPTH_BITS:0]   cnt_t;
    typedef logic [C_S_AXI_DATA_WIDTH-1:0] idx_t;

    typedef struct packed {
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    typedef enum logic [1:0] {WR_IDLE, WR_PKT, WR_DROP} wr_state_t;
    typedef enum logic [1:0] {IDLE, SEND, GAP} rd_state_t;

    beat_t     mem [DEPTH];
    ptr_t      wr_comm, wr_tent, rd_ptr;
    cnt_t      pkt_avail;
    wr_state_t wr_state;
    rd_state_t rd_state;
    idx_t      beat_idx;
    logic [TS_WIDTH-1:0] ts_reg;
    logic [15:0] gap_cnt;
    logic [31:0] seq;
    beat_t     head;
    logic      in_acc, fifo_full, commit, drop_evt, eg_last, ts_hit, sig_hit;
    logic      unused_tuser;

    assign unused_tuser  = ^s_axis_tuser;
    assign s_axis_tready = ~axis_reset;
    assign in_acc        = s_axis_tvalid & s_axis_tready;
    assign fifo_full     = (ptr_t'(wr_tent + ptr_t'(1)) == rd_ptr);
    assign commit        = in_acc & s_axis_tlast & (wr_state != WR_DROP) & ~fifo_full;
    assign drop_evt      = in_acc & s_axis_tlast & ((wr_state == WR_DROP) | fifo_full);
    assign head          = mem[rd_ptr];
    assign eg_last       = m_axis_tvalid & m_axis_tready & head.last;

    always_ff @(posedge axis_aclk) begin
        if (in_acc && wr_state != WR_DROP && !fifo_full)
            mem[wr_tent] <= '{last: s_axis_tlast, keep: s_axis_tkeep, data: s_axis_tdata};
    end

    // A beat that finds the FIFO full rewinds the tentative pointer, so the
    // partial packet vanishes without ever being visible to the reader.
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            wr_state      <= WR_IDLE;
            wr_comm       <= '0;
            wr_tent       <= '0;
            tx_drop_count <= '0;
        end else begin
            case (wr_state)
                WR_IDLE, WR_PKT: if (in_acc) begin
                    if (fifo_full) begin
                        wr_tent  <= wr_comm;
                        wr_state <= s_axis_tlast ? WR_IDLE : WR_DROP;
                    end else begin
                        wr_tent <= wr_tent + ptr_t'(1);
                        if (s_axis_tlast) begin
                            wr_comm  <= wr_tent + ptr_t'(1);
                            wr_state <= WR_IDLE;
                        end else begin
                            wr_state <= WR_PKT;
                        end
                    end
                end
                WR_DROP: if (in_acc && s_axis_tlast) wr_state <= WR_IDLE;
                default: wr_state <= WR_IDLE;
            endcase
            if (clear)         tx_drop_count <= '0;
            else if (drop_evt) tx_drop_count <= tx_drop_count + 32'd1;
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset)               pkt_avail <= '0;
        else if (commit && !eg_last)  pkt_avail <= pkt_avail + cnt_t'(1);
        else if (!commit && eg_last)  pkt_avail <= pkt_avail - cnt_t'(1);
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            rd_state      <= IDLE;
            rd_ptr        <= '0;
            beat_idx      <= '0;
            ts_reg        <= '0;
            gap_cnt       <= '0;
            m_axis_tvalid <= 1'b0;
            seq           <= '0;
            tx_pkt_count  <= '0;
        end else begin
            case (rd_state)
                IDLE: if (pkt_avail != '0) begin
                    rd_state      <= SEND;
                    m_axis_tvalid <= 1'b1;
                    ts_reg        <= timestamp_156;
                    beat_idx      <= idx_t'(1);
                end
                SEND: if (m_axis_tready) begin
                    rd_ptr   <= rd_ptr + ptr_t'(1);
                    beat_idx <= beat_idx + idx_t'(1);
                    if (head.last) begin
                        m_axis_tvalid <= 1'b0;
                        gap_cnt       <= tx_ipg;
                        rd_state      <= (tx_ipg != '0) ? GAP : IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt <= 16'd1) rd_state <= IDLE;
                    gap_cnt <= gap_cnt - 16'd1;
                end
                default: rd_state <= IDLE;
            endcase
            if (clear) begin
                seq          <= '0;
                tx_pkt_count <= '0;
            end else if (eg_last) begin
                seq          <= seq + 32'd1;
                tx_pkt_count <= tx_pkt_count + 32'd1;
            end
        end
    end

    assign ts_hit  = (tx_ts_pos != '0) && (beat_idx == tx_ts_pos);
    assign sig_hit = tx_sig_en && (tx_ts_pos != '0) && (beat_idx == idx_t'(tx_ts_pos + idx_t'(1)));

    always_comb begin
        logic [DW-1:0] d;
        d = head.data;
        if (ts_hit)  d[TS_WIDTH-1:0] = ts_reg;
        if (sig_hit) d[63:0] = {seq, SIGNATURE};
        m_axis_tdata = m_axis_tvalid ? d : '0;
        m_axis_tkeep = m_axis_tvalid ? head.keep : '0;
        m_axis_tlast = m_axis_tvalid & head.last;
        m_axis_tuser = 1'b0;
    end
endmodule

// File: tb/tb_osnt_tx_queue_sf.sv
// Directed bench for osnt_tx_queue_sf with a 16-entry FIFO.
module tb_osnt_tx_queue_sf;
    localparam logic [31:0] SIG = 32'hefbeadde;

    logic         axis_aclk = 1'b0;
    logic         axis_reset = 1'b1;
    logic [63:0]  s_axis_tdata = '0;
    logic [7:0]   s_axis_tkeep = '0;
    logic [127:0] s_axis_tuser = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic         s_axis_tlast = 1'b0;
    logic [63:0]  m_axis_tdata;
    logic [7:0]   m_axis_tkeep;
    logic         m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic         m_axis_tlast;
    logic         clear = 1'b0;
    logic [31:0]  tx_ts_pos = '0;
    logic         tx_sig_en = 1'b0;
    logic [15:0]  tx_ipg = '0;
    logic [63:0]  timestamp_156 = '0;
    logic [31:0]  tx_pkt_count, tx_drop_count;

    int checks = 0;
    int errors = 0;

    osnt_tx_queue_sf #(.FIFO_DEPTH_BITS(4)) dut (
        .axis_aclk(axis_aclk), .axis_reset(axis_reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .clear(clear), .tx_ts_pos(tx_ts_pos), .tx_sig_en(tx_sig_en), .tx_ipg(tx_ipg),
        .timestamp_156(timestamp_156), .tx_pkt_count(tx_pkt_count), .tx_drop_count(tx_drop_count)
    );

    always #5 axis_aclk = ~axis_aclk;

    // Output monitor: captured beats {last, keep, data}, idle gaps between packets,
    // hold-during-stall violations and ingress-ready drops.
    logic [72:0] mon_q[$];
    logic [72:0] exp_q[$];
    int gaps[$];
    int idle_cnt = 0, stab_err = 0, stab_chk = 0, rdy_low = 0;
    bit seen_last = 0, prev_stall = 0;
    logic [72:0] prev_out = '0;

    always @(negedge axis_aclk) begin
        if (axis_reset) begin
            prev_stall = 0;
            seen_last  = 0;
            idle_cnt   = 0;
        end else begin
            if (prev_stall) begin
                stab_chk++;
                if (!m_axis_tvalid || {m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== prev_out) stab_err++;
            end
            if (m_axis_tvalid) begin
                if (seen_last) begin
                    gaps.push_back(idle_cnt);
                    seen_last = 0;
                end
                idle_cnt = 0;
                if (m_axis_tready) begin
                    mon_q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
                    if (m_axis_tlast) seen_last = 1;
                end
            end else begin
                idle_cnt++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_out   = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
            if (!s_axis_tready) rdy_low++;
        end
    end

    function automatic logic [63:0] pat(input int p, input int i);
        return {16'hC0DE, 16'(p), 32'(i) ^ 32'h5A00_0000};
    endfunction

    task automatic clr_mon();
        mon_q.delete();
        exp_q.delete();
        gaps.delete();
        seen_last = 0;
        stab_err  = 0;
        stab_chk  = 0;
        rdy_low   = 0;
    endtask

    task automatic add_pkt(input int p, input int len, input logic [7:0] lastkeep);
        for (int i = 0; i < len; i++)
            exp_q.push_back({(i == len - 1), (i == len - 1) ? lastkeep : 8'hff, pat(p, i)});
    endtask

    task automatic set_exp(input int k, input logic [63:0] d);
        exp_q[k] = {exp_q[k][72:64], d};
    endtask

    task automatic send_pkt(input int p, input int len, input logic [7:0] lastkeep);
        for (int i = 0; i < len; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = pat(p, i);
            s_axis_tkeep  = (i == len - 1) ? lastkeep : 8'hff;
            s_axis_tlast  = (i == len - 1);
            s_axis_tuser  = {64'(p), 64'(i)};
            @(posedge axis_aclk); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string tag);
        int t;
        t = 0;
        while (mon_q.size() < n && t < 2000) begin
            @(posedge axis_aclk); #1;
            t++;
        end
        repeat (3) @(posedge axis_aclk);
        #1;
        checks++;
        if (mon_q.size() != n) begin
            $display("FAIL %s beat count: got %0d want %0d", tag, mon_q.size(), n);
            errors++;
        end
    endtask

    task automatic cmp_beats(input string tag);
        logic [72:0] got;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < mon_q.size()) ? mon_q[i] : 'x;
            checks++;
            if (got !== exp_q[i]) begin
                $display("FAIL %s beat %0d: got %h want %h", tag, i, got, exp_q[i]);
                errors++;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks += 6;
        if (s_axis_tready !== 1'b0) begin $display("FAIL reset tready: got %b want 0", s_axis_tready); errors++; end
        if (m_axis_tvalid !== 1'b0) begin $display("FAIL reset tvalid: got %b want 0", m_axis_tvalid); errors++; end
        if (m_axis_tlast !== 1'b0)  begin $display("FAIL reset tlast: got %b want 0", m_axis_tlast); errors++; end
        if ({m_axis_tkeep, m_axis_tdata} !== 72'd0) begin $display("FAIL reset tdata/tkeep: got %h want 0", {m_axis_tkeep, m_axis_tdata}); errors++; end
        if (tx_pkt_count !== 32'd0)  begin $display("FAIL reset pkt_count: got %0d want 0", tx_pkt_count); errors++; end
        if (tx_drop_count !== 32'd0) begin $display("FAIL reset drop_count: got %0d want 0", tx_drop_count); errors++; end
        repeat (2) @(posedge axis_aclk);
        #1 axis_reset = 1'b0;
        repeat (4) @(posedge axis_aclk);
        #1;
        checks += 3;
        if (s_axis_tready !== 1'b1) begin $display("FAIL post-reset tready: got %b want 1", s_axis_tready); errors++; end
        if (m_axis_tvalid !== 1'b0) begin $display("FAIL post-reset tvalid: got %b want 0", m_axis_tvalid); errors++; end
        if (m_axis_tuser !== 1'b0)  begin $display("FAIL tuser: got %b want 0", m_axis_tuser); errors++; end
    endtask

    task automatic test_passthru();
        clr_mon();
        for (int p = 0; p < 3; p++) add_pkt(p, 8, 8'h3f);
        for (int p = 0; p < 3; p++) send_pkt(p, 8, 8'h3f);
        wait_beats(24, "passthru");
        cmp_beats("passthru");
        checks += 2;
        if (gaps.size() != 2 || gaps[0] != 1 || gaps[1] != 1) begin
            $display("FAIL passthru gaps: got n=%0d g0=%0d g1=%0d want 2x1", gaps.size(),
                     gaps.size() > 0 ? gaps[0] : -1, gaps.size() > 1 ? gaps[1] : -1);
            errors++;
        end
        if (tx_pkt_count !== 32'd3) begin $display("FAIL passthru pkt_count: got %0d want 3", tx_pkt_count); errors++; end
    endtask

    task automatic test_timestamp();
        clear = 1'b1;
        @(posedge axis_aclk); #1 clear = 1'b0;
        tx_ts_pos = 32'd2;
        tx_sig_en = 1'b1;
        clr_mon();
        timestamp_156 = 64'h1234;
        add_pkt(10, 4, 8'hff);
        set_exp(1, 64'h1234);
        set_exp(2, {32'd0, SIG});
        send_pkt(10, 4, 8'hff);
        wait_beats(4, "ts pkt0");
        timestamp_156 = 64'h9999_0000_0000_1234;
        add_pkt(11, 3, 8'h0f);
        set_exp(5, 64'h9999_0000_0000_1234);
        set_exp(6, {32'd1, SIG});
        send_pkt(11, 3, 8'h0f);
        wait_beats(7, "ts pkt1");
        // signature position falls past the end of a 2-beat packet
        add_pkt(12, 2, 8'hff);
        set_exp(8, 64'h9999_0000_0000_1234);
        send_pkt(12, 2, 8'hff);
        wait_beats(9, "ts pkt2");
        tx_ts_pos = 32'd7;
        add_pkt(13, 3, 8'hff);
        send_pkt(13, 3, 8'hff);
        wait_beats(12, "ts pkt3");
        cmp_beats("timestamp");
        checks++;
        if (tx_pkt_count !== 32'd4) begin $display("FAIL ts pkt_count: got %0d want 4", tx_pkt_count); errors++; end
        tx_ts_pos = '0;
        tx_sig_en = 1'b0;
    endtask

    task automatic test_drop();
        clr_mon();
        send_pkt(20, 20, 8'hff);
        send_pkt(21, 4, 8'h07);
        add_pkt(21, 4, 8'h07);
        wait_beats(4, "drop oversize");
        cmp_beats("drop follow");
        checks++;
        if (tx_drop_count !== 32'd1) begin $display("FAIL drop count after 20-beat: got %0d want 1", tx_drop_count); errors++; end
        clr_mon();
        send_pkt(22, 16, 8'hff);
        repeat (10) @(posedge axis_aclk);
        #1;
        checks += 2;
        if (tx_drop_count !== 32'd2) begin $display("FAIL drop on tlast-full: got %0d want 2", tx_drop_count); errors++; end
        if (mon_q.size() != 0) begin $display("FAIL drop 16-beat leaked: got %0d beats want 0", mon_q.size()); errors++; end
        send_pkt(23, 15, 8'h01);
        add_pkt(23, 15, 8'h01);
        wait_beats(15, "drop fullfit");
        cmp_beats("full fit");
        checks += 2;
        if (rdy_low != 0) begin $display("FAIL s_axis_tready dropped: got %0d low cycles want 0", rdy_low); errors++; end
        if (tx_pkt_count !== 32'd6) begin $display("FAIL drop pkt_count: got %0d want 6", tx_pkt_count); errors++; end
    endtask

    task automatic test_ipg_stall();
        clr_mon();
        tx_ipg = 16'd5;
        for (int p = 30; p < 33; p++) add_pkt(p, 4, 8'h0f);
        fork
            begin
                for (int p = 30; p < 33; p++) send_pkt(p, 4, 8'h0f);
            end
            begin
                for (int c = 0; c < 600 && mon_q.size() < 12; c++) begin
                    m_axis_tready = (c < 12) ? 1'b0 : ($urandom_range(0, 2) != 0);
                    @(posedge axis_aclk); #1;
                end
                m_axis_tready = 1'b1;
            end
        join
        wait_beats(12, "ipg");
        cmp_beats("ipg");
        checks += 4;
        if (gaps.size() != 2 || gaps[0] != 6 || gaps[1] != 6) begin
            $display("FAIL ipg gaps: got n=%0d g0=%0d g1=%0d want 2x6", gaps.size(),
                     gaps.size() > 0 ? gaps[0] : -1, gaps.size() > 1 ? gaps[1] : -1);
            errors++;
        end
        if (stab_chk == 0) begin $display("FAIL ipg stalls seen: got 0 want >0"); errors++; end
        if (stab_err != 0) begin $display("FAIL ipg hold during stall: got %0d changes want 0", stab_err); errors++; end
        if (tx_pkt_count !== 32'd9) begin $display("FAIL ipg pkt_count: got %0d want 9", tx_pkt_count); errors++; end
        tx_ipg = '0;
    endtask

    task automatic test_clear_seq();
        int t;
        clr_mon();
        tx_ts_pos = 32'd1;
        tx_sig_en = 1'b1;
        timestamp_156 = 64'hDEAD_0001;
        add_pkt(40, 3, 8'hff);
        set_exp(0, 64'hDEAD_0001);
        set_exp(1, {32'd9, SIG});
        send_pkt(40, 3, 8'hff);
        t = 0;
        while (!(m_axis_tvalid && m_axis_tready && m_axis_tlast) && t < 100) begin
            @(negedge axis_aclk);
            t++;
        end
        checks++;
        if (t >= 100) begin $display("FAIL clear wait for tlast: timed out after %0d cycles", t); errors++; end
        clear = 1'b1;
        @(posedge axis_aclk); #1 clear = 1'b0;
        checks++;
        if (tx_pkt_count !== 32'd0) begin $display("FAIL clear vs tlast: got pkt_count %0d want 0", tx_pkt_count); errors++; end
        wait_beats(3, "clear pkt40");
        add_pkt(41, 2, 8'hff);
        set_exp(3, 64'hDEAD_0001);
        set_exp(4, {32'd0, SIG});
        send_pkt(41, 2, 8'hff);
        wait_beats(5, "clear pkt41");
        cmp_beats("clear seq");
        checks++;
        if (tx_pkt_count !== 32'd1) begin $display("FAIL post-clear pkt_count: got %0d want 1", tx_pkt_count); errors++; end
    endtask

    task automatic test_reset_mid();
        clr_mon();
        tx_ts_pos = '0;
        tx_sig_en = 1'b0;
        m_axis_tready = 1'b0;
        send_pkt(50, 6, 8'hff);
        repeat (2) @(posedge axis_aclk);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b1) begin $display("FAIL mid-reset precondition tvalid: got %b want 1", m_axis_tvalid); errors++; end
        m_axis_tready = 1'b1;
        repeat (2) @(posedge axis_aclk);
        #3 axis_reset = 1'b1;
        #1;
        checks += 3;
        if (m_axis_tvalid !== 1'b0) begin $display("FAIL mid-reset tvalid: got %b want 0", m_axis_tvalid); errors++; end
        if (s_axis_tready !== 1'b0) begin $display("FAIL mid-reset tready: got %b want 0", s_axis_tready); errors++; end
        if (m_axis_tdata !== 64'd0) begin $display("FAIL mid-reset tdata: got %h want 0", m_axis_tdata); errors++; end
        @(posedge axis_aclk); #1 axis_reset = 1'b0;
        clr_mon();
        repeat (10) @(posedge axis_aclk);
        #1;
        checks += 3;
        if (mon_q.size() != 0) begin $display("FAIL queue not empty after reset: got %0d beats want 0", mon_q.size()); errors++; end
        if (tx_pkt_count !== 32'd0) begin $display("FAIL post-reset pkt_count: got %0d want 0", tx_pkt_count); errors++; end
        if (tx_drop_count !== 32'd0) begin $display("FAIL post-reset drop_count: got %0d want 0", tx_drop_count); errors++; end
        tx_ts_pos = 32'd1;
        tx_sig_en = 1'b1;
        timestamp_156 = 64'h77;
        add_pkt(51, 3, 8'h01);
        set_exp(0, 64'h77);
        set_exp(1, {32'd0, SIG});
        send_pkt(51, 3, 8'h01);
        wait_beats(3, "after reset");
        cmp_beats("after reset");
    endtask

    initial begin
        test_reset();
        test_passthru();
        test_timestamp();
        test_drop();
        test_ipg_stall();
        test_clear_seq();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
